// File: rtl/trap_filter_pd.sv
// Trapezoidal pulse shaper with run-time K/L delays, test-pattern source, bypass,
// scaled/saturated output and a flush sequencer that zeroes the delay memory.
module trap_filter_pd #(
    parameter int unsigned SIZE_ADC_DATA     = 14,
    parameter int unsigned SIZE_FILTER_DATA  = 16,
    parameter int unsigned SIZE_DELAY        = 7,
    parameter int unsigned SIZE_TEST_COUNTER = 16,
    parameter int unsigned SIZE_ACC          = SIZE_ADC_DATA + 2*SIZE_DELAY + 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_load,
    input  logic [SIZE_DELAY-1:0]       cfg_k,
    input  logic [SIZE_DELAY-1:0]       cfg_l,
    input  logic [3:0]                  cfg_shift,
    input  logic [1:0]                  cfg_mode,
    input  logic [SIZE_ADC_DATA-1:0]    in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [SIZE_FILTER_DATA-1:0] out_data,
    output logic                        out_valid,
    output logic                        cfg_err,
    output logic                        sat_flag
);
    localparam int unsigned DEPTH = 2**SIZE_DELAY;
    localparam int unsigned DW    = SIZE_ADC_DATA + 3;
    localparam int unsigned SW    = SIZE_DELAY + 1;
    localparam logic signed [SIZE_ACC-1:0] OUT_MAX = SIZE_ACC'(2**(SIZE_FILTER_DATA-1) - 1);
    localparam logic signed [SIZE_ACC-1:0] OUT_MIN = SIZE_ACC'(-(2**(SIZE_FILTER_DATA-1)));

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [SIZE_DELAY-1:0]        k_r;
    logic [SIZE_DELAY-1:0]        l_r;
    logic [3:0]                   shift_r;
    logic [1:0]                   mode_r;
    logic [SIZE_DELAY-1:0]        flush_cnt;
    logic [SIZE_DELAY-1:0]        wp;
    logic [SIZE_TEST_COUNTER-1:0] tcnt;
    logic [SIZE_ADC_DATA-1:0]     mem [DEPTH];

    logic                         cfg_bad;
    logic [SW-1:0]                kl_sum;
    logic                         flush_last;
    logic                         accept;
    logic                         src_cnt;
    logic                         bypass;
    logic [SIZE_ADC_DATA-1:0]     x;
    logic [SIZE_ADC_DATA-1:0]     tap_k;
    logic [SIZE_ADC_DATA-1:0]     tap_l;
    logic [SIZE_ADC_DATA-1:0]     tap_kl;
    logic signed [DW-1:0]         d;
    logic signed [SIZE_ACC-1:0]   acc_shift;

    logic                         s1_valid;
    logic                         s2_valid;
    logic signed [DW-1:0]         d_r;
    logic [SIZE_ADC_DATA-1:0]     x_r1;
    logic [SIZE_ADC_DATA-1:0]     x_r2;
    logic signed [SIZE_ACC-1:0]   acc;

    // Config validation is done on the raw cfg_* inputs so cfg_err lands with the load.
    assign kl_sum  = SW'(cfg_k) + SW'(cfg_l);
    assign cfg_bad = (cfg_k == '0) || (cfg_l == '0) || (cfg_k < cfg_l)
                   || (kl_sum > SW'(DEPTH - 1));

    assign flush_last = (flush_cnt == SIZE_DELAY'(DEPTH - 1));
    assign src_cnt    = (mode_r == 2'd2);
    assign bypass     = (mode_r == 2'd1);
    assign accept     = in_valid && in_ready && !cfg_load;
    assign x          = src_cnt ? tcnt[SIZE_ADC_DATA-1:0] : in_data;

    // Taps are read before this sample's write lands at wp.
    assign tap_k  = mem[wp - k_r];
    assign tap_l  = mem[wp - l_r];
    assign tap_kl = mem[wp - k_r - l_r];
    assign d      = DW'(x) - DW'(tap_k) - DW'(tap_l) + DW'(tap_kl);

    assign acc_shift = acc >>> shift_r;

    generate
        if (SIZE_TEST_COUNTER > SIZE_ADC_DATA) begin : g_tcnt_hi
            logic tcnt_hi_unused;
            assign tcnt_hi_unused = ^tcnt[SIZE_TEST_COUNTER-1:SIZE_ADC_DATA];
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            ST_FLUSH: if (flush_last) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            ST_ERR:   state_next = ST_ERR;
            default:  state_next = ST_FLUSH;
        endcase
        if (cfg_load) state_next = cfg_bad ? ST_ERR : ST_FLUSH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_FLUSH;
            in_ready  <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == ST_RUN);
            if (cfg_load || state != ST_FLUSH) flush_cnt <= '0;
            else                               flush_cnt <= flush_cnt + SIZE_DELAY'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r     <= SIZE_DELAY'(1);
            l_r     <= SIZE_DELAY'(1);
            shift_r <= '0;
            mode_r  <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            k_r     <= cfg_k;
            l_r     <= cfg_l;
            shift_r <= cfg_shift;
            mode_r  <= cfg_mode;
            cfg_err <= cfg_bad;
        end
    end

    // Delay memory: cleared by the flush walk, otherwise one write per accepted sample.
    always_ff @(posedge clk) begin
        if (state == ST_FLUSH) mem[flush_cnt] <= '0;
        else if (accept)       mem[wp] <= x;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp   <= '0;
            tcnt <= '0;
        end else begin
            if (cfg_load || state != ST_RUN) wp <= '0;
            else if (accept)                 wp <= wp + SIZE_DELAY'(1);
            if (accept && src_cnt) tcnt <= tcnt + SIZE_TEST_COUNTER'(1);
        end
    end

    // Three-stage datapath: difference, accumulate, scale/saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            d_r       <= '0;
            x_r1      <= '0;
            x_r2      <= '0;
            acc       <= '0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else if (cfg_load || state != ST_RUN) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            d_r       <= '0;
            acc       <= '0;
            if (cfg_load) sat_flag <= 1'b0;
        end else begin
            s1_valid  <= accept;
            d_r       <= d;
            x_r1      <= x;
            s2_valid  <= s1_valid;
            x_r2      <= x_r1;
            if (s1_valid) acc <= acc + SIZE_ACC'(d_r);
            out_valid <= s2_valid;
            if (s2_valid) begin
                if (bypass) begin
                    out_data <= SIZE_FILTER_DATA'(x_r2);
                end else if (acc_shift > OUT_MAX) begin
                    out_data <= SIZE_FILTER_DATA'(OUT_MAX);
                    sat_flag <= 1'b1;
                end else if (acc_shift < OUT_MIN) begin
                    out_data <= SIZE_FILTER_DATA'(OUT_MIN);
                    sat_flag <= 1'b1;
                end else begin
                    out_data <= SIZE_FILTER_DATA'(acc_shift);
                end
            end
        end
    end

endmodule
